fetch_decode_queue: RTL and testbench

Parametrised fetch-to-decode buffer for the RISC-V core. It accepts fetched instruction words with their PCs over a valid/ready handshake, decodes register addresses and operand-usage flags at enqueue, and holds the decoded entries in a DEPTH-entry FIFO. The register file and hazard logic read the entries through a second valid/ready handshake. It replaces the purely combinational register-address extraction between fetch and the register file, and adds buffering, back-pressure, flush, RV32E support and illegal-instruction detection.

---
 rtl/riscv_dec_pkg.sv | 30 +++
 rtl/inst_field_decode.sv | 52 +++++
 rtl/fetch_decode_queue.sv | 117 +++++++++++
 tb/tb_fetch_decode_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dec_pkg.sv
// Shared RISC-V decode definitions: base opcodes and the decoded entry
// carried through the fetch-to-decode buffer.
package riscv_dec_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Register fields are kept at full RV32I width; RV32E users truncate on read.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [4:0]  waddr;
    logic        use_rs1;
    logic        use_rs2;
    logic        rd_we;
    logic        illegal;
  } dec_entry_t;

endpackage

// File: rtl/inst_field_decode.sv
// Combinational register-field decode: addresses, operand-usage flags and
// illegal-instruction detection (including the RV32E register limit).
module inst_field_decode
  import riscv_dec_pkg::*;
#(
  parameter int unsigned RV32E  = 0,
  parameter int unsigned REG_AW = 5
) (
  input  logic [31:0]       inst,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  output logic [REG_AW-1:0] waddr,
  output logic              use_rs1,
  output logic              use_rs2,
  output logic              rd_we,
  output logic              illegal
);

  logic cls_rs1, cls_rs2, cls_rd, known, e_bad;
  logic unused_bits;

  assign unused_bits = ^{inst[31:25], inst[14:12]};

  assign raddr1 = inst[15 +: REG_AW];
  assign raddr2 = inst[20 +: REG_AW];
  assign waddr  = inst[7 +: REG_AW];

  always_comb begin
    cls_rs1 = 1'b0;
    cls_rs2 = 1'b0;
    cls_rd  = 1'b0;
    known   = (inst[1:0] == 2'b11);
    unique case (inst[6:0])
      OP_R:                      begin cls_rs1 = 1'b1; cls_rs2 = 1'b1; cls_rd = 1'b1; end
      OP_IMM, OP_LOAD, OP_JALR:  begin cls_rs1 = 1'b1; cls_rd = 1'b1; end
      OP_STORE, OP_BRANCH:       begin cls_rs1 = 1'b1; cls_rs2 = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL:  cls_rd = 1'b1;
      OP_FENCE, OP_SYSTEM:       ;
      default:                   known = 1'b0;
    endcase
  end

  // Only fields the opcode actually reads or writes can trip the RV32E limit.
  assign e_bad   = (RV32E != 0) &&
                   ((cls_rs1 && inst[19]) || (cls_rs2 && inst[24]) || (cls_rd && inst[11]));
  assign illegal = !known || e_bad;

  assign use_rs1 = !illegal && cls_rs1 && (inst[19:15] != '0);
  assign use_rs2 = !illegal && cls_rs2 && (inst[24:20] != '0);
  assign rd_we   = !illegal && cls_rd  && (inst[11:7]  != '0);

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode buffer: decodes register fields at enqueue and holds the
// decoded entries in a DEPTH-entry circular FIFO with flush.
module fetch_decode_queue
  import riscv_dec_pkg::*;
#(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned DEPTH  = 2,
  parameter  int unsigned RV32E  = 0,
  localparam int unsigned REG_AW = (RV32E != 0) ? 4 : 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_inst,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  output logic [REG_AW-1:0] waddr,
  output logic              use_rs1,
  output logic              use_rs2,
  output logic              rd_we,
  output logic              illegal
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  dec_entry_t        mem [DEPTH];
  dec_entry_t        new_entry, head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop;
  logic [REG_AW-1:0] d_raddr1, d_raddr2, d_waddr;
  logic              d_use_rs1, d_use_rs2, d_rd_we, d_illegal;
  logic              unused_hi;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  inst_field_decode #(
    .RV32E  (RV32E),
    .REG_AW (REG_AW)
  ) u_dec (
    .inst    (in_inst),
    .raddr1  (d_raddr1),
    .raddr2  (d_raddr2),
    .waddr   (d_waddr),
    .use_rs1 (d_use_rs1),
    .use_rs2 (d_use_rs2),
    .rd_we   (d_rd_we),
    .illegal (d_illegal)
  );

  always_comb begin
    new_entry         = '0;
    new_entry.pc      = in_pc;
    new_entry.inst    = in_inst;
    new_entry.raddr1  = 5'(d_raddr1);
    new_entry.raddr2  = 5'(d_raddr2);
    new_entry.waddr   = 5'(d_waddr);
    new_entry.use_rs1 = d_use_rs1;
    new_entry.use_rs2 = d_use_rs2;
    new_entry.rd_we   = d_rd_we;
    new_entry.illegal = d_illegal;
  end

  // in_ready depends only on count, so a pop never frees a slot in the same cycle.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign unused_hi = ^{head.raddr1[4], head.raddr2[4], head.waddr[4]};

  assign out_pc   = head.pc;
  assign out_inst = head.inst;
  assign raddr1   = head.raddr1[REG_AW-1:0];
  assign raddr2   = head.raddr2[REG_AW-1:0];
  assign waddr    = head.waddr[REG_AW-1:0];
  assign use_rs1  = head.use_rs1;
  assign use_rs2  = head.use_rs2;
  assign rd_we    = head.rd_we;
  assign illegal  = head.illegal;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench: two buffer instances (DEPTH=2 RV32I, DEPTH=3 RV32E) share
// stimulus; each has a queue-based reference model checked at every negedge.
module tb_fetch_decode_queue;

  typedef struct {
    logic        inr;
    logic        ov;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  r1, r2, wd;
    logic        u1, u2, we, ill;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        a_inr, a_ov, a_u1, a_u2, a_we, a_ill;
  logic [31:0] a_pc, a_inst;
  logic [4:0]  a_r1, a_r2, a_wd;
  logic        b_inr, b_ov, b_u1, b_u2, b_we, b_ill;
  logic [31:0] b_pc, b_inst;
  logic [3:0]  b_r1, b_r2, b_wd;

  int   n_chk  = 0;
  int   n_fail = 0;
  obs_t q0[$];
  obs_t q1[$];

  always #5 clk = ~clk;

  fetch_decode_queue #(.XLEN(32), .DEPTH(2), .RV32E(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_inr),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(a_ov),
    .out_ready(out_ready), .out_pc(a_pc), .out_inst(a_inst),
    .raddr1(a_r1), .raddr2(a_r2), .waddr(a_wd), .use_rs1(a_u1),
    .use_rs2(a_u2), .rd_we(a_we), .illegal(a_ill)
  );

  fetch_decode_queue #(.XLEN(32), .DEPTH(3), .RV32E(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_inr),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(b_ov),
    .out_ready(out_ready), .out_pc(b_pc), .out_inst(b_inst),
    .raddr1(b_r1), .raddr2(b_r2), .waddr(b_wd), .use_rs1(b_u1),
    .use_rs2(b_u2), .rd_we(b_we), .illegal(b_ill)
  );

  // Reference decode straight from the ISA operand table.
  function automatic obs_t ref_dec(input logic [31:0] inst, input logic [31:0] pc, input bit e);
    obs_t    o;
    bit [2:0] u;
    bit      legal;
    int      f1, f2, fd;
    u = 3'b000;
    legal = 1'b1;
    case (inst[6:0])
      7'h33:               u = 3'b111;
      7'h13, 7'h03, 7'h67: u = 3'b101;
      7'h23, 7'h63:        u = 3'b110;
      7'h37, 7'h17, 7'h6f: u = 3'b001;
      7'h0f, 7'h73:        u = 3'b000;
      default:             legal = 1'b0;
    endcase
    f1 = int'(inst[19:15]);
    f2 = int'(inst[24:20]);
    fd = int'(inst[11:7]);
    if (e && ((u[2] && f1 >= 16) || (u[1] && f2 >= 16) || (u[0] && fd >= 16))) legal = 1'b0;
    o.inr  = 1'b0;
    o.ov   = 1'b0;
    o.pc   = pc;
    o.inst = inst;
    o.r1   = e ? 5'(f1 % 16) : 5'(f1);
    o.r2   = e ? 5'(f2 % 16) : 5'(f2);
    o.wd   = e ? 5'(fd % 16) : 5'(fd);
    o.u1   = legal && u[2] && f1 != 0;
    o.u2   = legal && u[1] && f2 != 0;
    o.we   = legal && u[0] && fd != 0;
    o.ill  = !legal;
    return o;
  endfunction

  function automatic obs_t get_obs(input int k);
    obs_t o;
    if (k == 0) begin
      o.inr = a_inr; o.ov = a_ov; o.pc = a_pc; o.inst = a_inst;
      o.r1 = a_r1; o.r2 = a_r2; o.wd = a_wd;
      o.u1 = a_u1; o.u2 = a_u2; o.we = a_we; o.ill = a_ill;
    end else begin
      o.inr = b_inr; o.ov = b_ov; o.pc = b_pc; o.inst = b_inst;
      o.r1 = {1'b0, b_r1}; o.r2 = {1'b0, b_r2}; o.wd = {1'b0, b_wd};
      o.u1 = b_u1; o.u2 = b_u2; o.we = b_we; o.ill = b_ill;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, got, exp, $time);
    end
  endtask

  task automatic chk_fields(input string pfx, input int k, input obs_t g, input obs_t x);
    chk({pfx, "out_pc"},   k, 64'(g.pc),   64'(x.pc));
    chk({pfx, "out_inst"}, k, 64'(g.inst), 64'(x.inst));
    chk({pfx, "raddr1"},   k, 64'(g.r1),   64'(x.r1));
    chk({pfx, "raddr2"},   k, 64'(g.r2),   64'(x.r2));
    chk({pfx, "waddr"},    k, 64'(g.wd),   64'(x.wd));
    chk({pfx, "use_rs1"},  k, 64'(g.u1),   64'(x.u1));
    chk({pfx, "use_rs2"},  k, 64'(g.u2),   64'(x.u2));
    chk({pfx, "rd_we"},    k, 64'(g.we),   64'(x.we));
    chk({pfx, "illegal"},  k, 64'(g.ill),  64'(x.ill));
  endtask

  // Monitor/scoreboard: compare against the model state, then apply this cycle's handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic int   depth = (k == 0) ? 2 : 3;
        automatic int   sz    = (k == 0) ? q0.size() : q1.size();
        automatic obs_t g     = get_obs(k);
        automatic obs_t x;
        automatic bit   do_pop, do_push;
        chk("in_ready",  k, 64'(g.inr), 64'(sz < depth));
        chk("out_valid", k, 64'(g.ov),  64'(sz > 0));
        if (sz > 0) begin
          x = (k == 0) ? q0[0] : q1[0];
          chk_fields("head_", k, g, x);
        end
        do_pop  = (sz > 0) && out_ready && !flush;
        do_push = in_valid && (sz < depth) && !flush;
        if (flush) begin
          if (k == 0) q0.delete(); else q1.delete();
        end else begin
          if (do_pop) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end
          if (do_push) begin
            x = ref_dec(in_inst, in_pc, k == 1);
            if (k == 0) q0.push_back(x); else q1.push_back(x);
          end
        end
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] i, input logic [31:0] p, input bit f, input bit r);
    in_valid  = v;
    in_inst   = i;
    in_pc     = p;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string pfx);
    obs_t z;
    z = ref_dec(32'h0, 32'h0, 1'b0);
    z.ill = 1'b0;
    for (int k = 0; k < 2; k++) begin
      automatic obs_t g = get_obs(k);
      chk({pfx, "in_ready"},  k, 64'(g.inr), 64'(1));
      chk({pfx, "out_valid"}, k, 64'(g.ov),  64'(0));
      chk_fields(pfx, k, g, z);
    end
  endtask

  logic [6:0] ops [13] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                           7'h17, 7'h6f, 7'h0f, 7'h73, 7'h7f, 7'h0b};

  function automatic logic [31:0] rnd_inst();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 12)];
    return w;
  endfunction

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0;
    in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk_reset_state("rst_");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // add x0,x1,x2 held, then popped
    step(1, 32'h0020_8033, 32'h100, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 1);

    // fill past DEPTH with the consumer stalled, then drain in order
    step(1, 32'h0050_0093, 32'h104, 0, 0);
    step(1, 32'h0010_2023, 32'h108, 0, 0);
    step(1, 32'h0000_0013, 32'h10c, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    repeat (4) step(0, 32'h0, 32'h0, 0, 1);

    // illegal encodings
    step(1, 32'hFFFF_FFFF, 32'h200, 0, 1);
    step(1, 32'h0000_007F, 32'h204, 0, 1);
    repeat (2) step(0, 32'h0, 32'h0, 0, 1);

    // RV32E: immediate bits vs. a real x16 operand
    step(1, 32'h0100_0093, 32'h300, 0, 0);
    step(1, 32'h0100_00B3, 32'h304, 0, 0);
    repeat (3) step(0, 32'h0, 32'h0, 0, 1);

    // flush with a concurrent push
    step(1, 32'h0030_0113, 32'h400, 0, 0);
    step(1, 32'h0040_0193, 32'h404, 0, 0);
    step(1, 32'h0050_0213, 32'h408, 1, 0);
    repeat (2) step(0, 32'h0, 32'h0, 0, 1);

    // steady-state streaming, wrapping both pointers several times
    pc = 32'h500;
    repeat (12) begin
      step(1, rnd_inst(), pc, 0, 1);
      pc += 4;
    end
    repeat (4) step(0, 32'h0, 32'h0, 0, 1);

    // randomized traffic with occasional flush and one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst_");
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, rnd_inst(), pc,
           $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);
      pc += 4;
    end
    repeat (5) step(0, 32'h0, 32'h0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 required");
    $fatal(1, "timeout");
  end

endmodule
